// File: rtl/fft_exp_normalizer.sv
// Normalizes block-floating-point FFT bins to fixed OUT_W-bit samples using the frame exponent.
// Define FFT_FRAME_CHECK_EN to add sop/eop/length frame-integrity checking on the sink port.
module fft_exp_normalizer #(
  parameter int N     = 1024,
  parameter int OUT_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sink_valid,
  output logic             sink_ready,
  input  logic [1:0]       sink_error,
  input  logic             sink_sop,
  input  logic             sink_eop,
  input  logic [15:0]      sink_real,
  input  logic [15:0]      sink_imag,
  input  logic [5:0]       sink_exp,
  output logic             source_valid,
  input  logic             source_ready,
  output logic [1:0]       source_error,
  output logic             source_sop,
  output logic             source_eop,
  output logic [OUT_W-1:0] source_real,
  output logic [OUT_W-1:0] source_imag
);

  generate
    if (N < 8 || N > 65536 || (N & (N - 1)) != 0 || OUT_W < 17 || OUT_W > 32) begin : g_param_check
      $error("fft_exp_normalizer: N or OUT_W out of range");
    end
  endgenerate

  localparam logic signed [63:0] MAX_V = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
  localparam logic signed [63:0] MIN_V = -(64'sd1 <<< (OUT_W - 1));

  logic        advance;
  logic        take;
  logic [5:0]  exp_reg;
  logic [5:0]  use_exp;
  logic [1:0]  chk_err;

  logic        s1_valid;
  logic        s1_sop;
  logic        s1_eop;
  logic [1:0]  s1_error;
  logic [15:0] s1_real;
  logic [15:0] s1_imag;
  logic [5:0]  s1_exp;

  // Both stages move together; a stalled full S2 freezes the whole pipe.
  assign advance    = !source_valid || source_ready;
  assign sink_ready = reset_n && advance;
  assign take       = sink_valid && sink_ready;

  // A 64-bit intermediate holds the largest left shift (16 + 32 bits) without loss.
  function automatic logic [OUT_W-1:0] normalize(input logic [15:0] sample, input logic [5:0] e);
    logic signed [63:0] wide;
    int                 amt;
    amt  = int'($signed(e));
    wide = {{48{sample[15]}}, sample};
    if (amt <= 0) wide = wide <<< (-amt);
    else          wide = wide >>> amt;
    if (wide > MAX_V)      normalize = MAX_V[OUT_W-1:0];
    else if (wide < MIN_V) normalize = MIN_V[OUT_W-1:0];
    else                   normalize = wide[OUT_W-1:0];
  endfunction

`ifdef FFT_FRAME_CHECK_EN
  localparam int CW = $clog2(N);

  typedef enum logic {IDLE, IN_FRAME} frame_state_t;

  frame_state_t   state;
  frame_state_t   state_next;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_next;
  logic [CW-1:0]  idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (take) begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // idx is the position of the sample currently offered; cnt tracks the next one.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CW'(1);
    chk_err    = 2'b00;
    use_exp    = exp_reg;
    idx        = sink_sop ? '0 : cnt;
    if (sink_sop) begin
      use_exp    = sink_exp;
      state_next = IN_FRAME;
      cnt_next   = CW'(1);
      if (state == IN_FRAME) chk_err[1] = 1'b1;
    end else if (state == IDLE) begin
      use_exp    = '0;
      chk_err[0] = 1'b1;
      cnt_next   = cnt;
    end
    if (sink_sop || state == IN_FRAME) begin
      if (sink_eop != (idx == CW'(N - 1))) begin
        chk_err[1] = 1'b1;
        state_next = IDLE;
      end else if (sink_eop) begin
        state_next = IDLE;
      end
    end
  end
`else
  assign chk_err = 2'b00;
  assign use_exp = sink_sop ? sink_exp : exp_reg;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              exp_reg <= '0;
    else if (take && sink_sop) exp_reg <= sink_exp;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_sop   <= 1'b0;
      s1_eop   <= 1'b0;
      s1_error <= 2'b00;
      s1_real  <= '0;
      s1_imag  <= '0;
      s1_exp   <= '0;
    end else if (advance) begin
      s1_valid <= sink_valid;
      s1_sop   <= sink_sop;
      s1_eop   <= sink_eop;
      s1_error <= sink_error | chk_err;
      s1_real  <= sink_real;
      s1_imag  <= sink_imag;
      s1_exp   <= use_exp;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_error <= 2'b00;
      source_real  <= '0;
      source_imag  <= '0;
    end else if (advance) begin
      source_valid <= s1_valid;
      if (s1_valid) begin
        source_sop   <= s1_sop;
        source_eop   <= s1_eop;
        source_error <= s1_error;
        source_real  <= normalize(s1_real, s1_exp);
        source_imag  <= normalize(s1_imag, s1_exp);
      end
    end
  end

endmodule

// File: tb/tb_fft_exp_normalizer.sv
// Directed bench for fft_exp_normalizer: vector table, full frames, backpressure and reset.
// A second instance with OUT_W=17 covers narrow-output saturation.
module tb_fft_exp_normalizer;

  localparam int N = 1024;

`ifdef FFT_FRAME_CHECK_EN
  localparam logic [1:0] SOLO_ERR = 2'b10;
`else
  localparam logic [1:0] SOLO_ERR = 2'b00;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        sink_valid = 1'b0;
  logic [1:0]  sink_error = 2'b00;
  logic        sink_sop = 1'b0;
  logic        sink_eop = 1'b0;
  logic [15:0] sink_real = '0;
  logic [15:0] sink_imag = '0;
  logic [5:0]  sink_exp = '0;
  logic        source_ready = 1'b1;

  logic        sink_ready, source_valid, source_sop, source_eop;
  logic [1:0]  source_error;
  logic [23:0] source_real, source_imag;

  logic        sink_ready17, source_valid17, source_sop17, source_eop17;
  logic [1:0]  source_error17;
  logic [16:0] source_real17, source_imag17;

  int checks = 0;
  int errors = 0;

  fft_exp_normalizer #(.N(N), .OUT_W(24)) dut (
    .clk(clk), .reset_n(reset_n),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_error(sink_error),
    .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
    .sink_exp(sink_exp),
    .source_valid(source_valid), .source_ready(source_ready), .source_error(source_error),
    .source_sop(source_sop), .source_eop(source_eop),
    .source_real(source_real), .source_imag(source_imag)
  );

  fft_exp_normalizer #(.N(N), .OUT_W(17)) dut17 (
    .clk(clk), .reset_n(reset_n),
    .sink_valid(sink_valid), .sink_ready(sink_ready17), .sink_error(sink_error),
    .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
    .sink_exp(sink_exp),
    .source_valid(source_valid17), .source_ready(source_ready), .source_error(source_error17),
    .source_sop(source_sop17), .source_eop(source_eop17),
    .source_real(source_real17), .source_imag(source_imag17)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]        re;
    logic [15:0]        im;
    logic signed [5:0]  e;
    int                 re24;
    int                 im24;
    int                 re17;
    int                 im17;
  } vec_t;

  typedef struct {
    longint re;
    longint im;
    logic   sop;
    logic   eop;
  } exp_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic sop, input logic eop, input logic [5:0] e,
                               input logic [15:0] re, input logic [15:0] im, input logic [1:0] err);
    sink_valid = v;
    sink_sop   = sop;
    sink_eop   = eop;
    sink_exp   = e;
    sink_real  = re;
    sink_imag  = im;
    sink_error = err;
  endtask

  // Independent reference: multiply / floor-divide then clamp.
  function automatic longint refNorm(input int s, input int e, input int w);
    longint v, d, hi, lo;
    if (e <= 0) begin
      v = longint'(s) * (longint'(1) << (-e));
    end else begin
      d = longint'(1) << e;
      v = longint'(s) / d;
      if ((longint'(s) % d) != 0 && s < 0) v = v - 1;
    end
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Streams a frame of constant 0x0100/0xFF00 bins (exp -3 on sop, junk exp afterwards).
  task automatic runFrame(input int len, input int eop_idx, input int bad_idx,
                          input logic [1:0] bad_err, input string tag);
    int bad;
    int k;
    bad = 0;
    for (int j = 0; j < len + 2; j++) begin
      if (j == 1) checkOutput({tag, " no output at 1 cycle"}, source_valid, 0);
      if (j == 2) checkOutput({tag, " output at 2 cycles"}, source_valid, 1);
      if (j >= 2) begin
        k = j - 2;
        if (source_valid !== 1'b1) bad++;
        if (longint'($signed(source_real)) != 2048) bad++;
        if (longint'($signed(source_imag)) != -2048) bad++;
        if (source_sop !== (k == 0)) bad++;
        if (source_eop !== (k == eop_idx)) bad++;
        if (source_error !== ((k == bad_idx) ? bad_err : 2'b00)) bad++;
        if (k == bad_idx) checkOutput({tag, " error flag"}, source_error, bad_err);
      end
      if (j < len) applyStimulus(1'b1, j == 0, j == eop_idx, (j == 0) ? 6'h3D : 6'd7,
                                 16'h0100, 16'hFF00, 2'b00);
      else         applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 16'h0, 2'b00);
      step();
    end
    checkOutput({tag, " bad samples"}, bad, 0);
  endtask

  task automatic stallTest();
    exp_t   q[$];
    exp_t   item, got;
    int     sent, recv, value_bad, stable_bad, ready_bad, cyc;
    logic   prev_hold;
    logic [52:0] prev, snap;
    int     re_i, im_i;
    sent = 0; recv = 0; value_bad = 0; stable_bad = 0; ready_bad = 0; cyc = 0;
    prev_hold = 1'b0;
    prev = '0;
    while ((sent < N || recv < N) && cyc < 20000) begin
      source_ready = 1'($urandom_range(0, 1));
      re_i = ((sent * 97) % 65536) - 32768;
      im_i = 32767 - sent * 61;
      if (sent < N) applyStimulus(1'b1, sent == 0, sent == N - 1,
                                  (sent == 0) ? 6'h3E : 6'($urandom_range(0, 63)),
                                  16'(re_i), 16'(im_i), 2'b00);
      else          applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 16'h0, 2'b00);
      #2;
      if (sink_ready !== (!source_valid || source_ready)) ready_bad++;
      snap = {source_valid, source_sop, source_eop, source_error, source_real, source_imag};
      if (prev_hold && snap !== prev) stable_bad++;
      if (source_valid && source_ready) begin
        if (q.size() == 0) begin
          value_bad++;
        end else begin
          got = q.pop_front();
          if (longint'($signed(source_real)) != got.re || longint'($signed(source_imag)) != got.im ||
              source_sop !== got.sop || source_eop !== got.eop || source_error !== 2'b00)
            value_bad++;
        end
        recv++;
      end
      if (sink_valid && sink_ready) begin
        item.re  = refNorm(re_i, -2, 24);
        item.im  = refNorm(im_i, -2, 24);
        item.sop = (sent == 0);
        item.eop = (sent == N - 1);
        q.push_back(item);
        sent++;
      end
      prev_hold = source_valid && !source_ready;
      prev = snap;
      cyc++;
      step();
    end
    source_ready = 1'b1;
    checkOutput("stall samples sent", sent, N);
    checkOutput("stall samples received", recv, N);
    checkOutput("stall leftover expected", q.size(), 0);
    checkOutput("stall value errors", value_bad, 0);
    checkOutput("stall stability errors", stable_bad, 0);
    checkOutput("stall sink_ready errors", ready_bad, 0);
  endtask

  initial begin
    int nv;
    int stale;
    vecs[0] = '{16'h0100, 16'hFF00, -6'sd3,        2048,    -2048,  2048,  -2048};
    vecs[1] = '{16'h8001, 16'h0003,  6'sd2,       -8192,        0, -8192,      0};
    vecs[2] = '{16'h7FFF, 16'h8000, -6'sd4,      524272,  -524288, 65535, -65536};
    vecs[3] = '{16'd1234, 16'hFFFF,  6'sd0,        1234,       -1,  1234,     -1};
    vecs[4] = '{16'h0001, 16'hFFFF, -6'sd32,    8388607, -8388608, 65535, -65536};
    vecs[5] = '{16'h7FFF, 16'h8000,  6'sd31,          0,       -1,     0,     -1};
    vecs[6] = '{16'h7FFF, 16'h8000, -6'sd8,     8388352, -8388608, 65535, -65536};
    vecs[7] = '{16'hFFFF, 16'd100,  -6'sd9,        -512,    51200,  -512,  51200};
    vecs[8] = '{16'hFFFF, 16'h0001,  6'sd1,          -1,        0,    -1,      0};
    nv = 9;

    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset source_valid", source_valid, 0);
    checkOutput("reset sink_ready", sink_ready, 0);
    checkOutput("reset source_real", source_real, 0);
    checkOutput("reset source_imag", source_imag, 0);
    checkOutput("reset source_sop", source_sop, 0);
    checkOutput("reset source_eop", source_eop, 0);
    checkOutput("reset source_error", source_error, 0);
    reset_n = 1'b1;
    #1;
    checkOutput("sink_ready after reset release", sink_ready, 1);

    // Table: one-sample frames streamed back to back, each checked two cycles later.
    for (int j = 0; j < nv + 2; j++) begin
      if (j >= 2) begin
        checkOutput($sformatf("vec%0d valid", j - 2), source_valid, 1);
        checkOutput($sformatf("vec%0d real", j - 2), longint'($signed(source_real)), vecs[j-2].re24);
        checkOutput($sformatf("vec%0d imag", j - 2), longint'($signed(source_imag)), vecs[j-2].im24);
        checkOutput($sformatf("vec%0d sop/eop", j - 2), {source_sop, source_eop}, 3);
        checkOutput($sformatf("vec%0d error", j - 2), source_error, 2'((j - 2) % 4) | SOLO_ERR);
        checkOutput($sformatf("vec%0d w17 valid", j - 2), source_valid17, 1);
        checkOutput($sformatf("vec%0d w17 real", j - 2), longint'($signed(source_real17)), vecs[j-2].re17);
        checkOutput($sformatf("vec%0d w17 imag", j - 2), longint'($signed(source_imag17)), vecs[j-2].im17);
        checkOutput($sformatf("vec%0d w17 sop/eop/err", j - 2),
                    {source_sop17, source_eop17, source_error17},
                    {2'b11, 2'((j - 2) % 4) | SOLO_ERR});
      end
      if (j < nv) begin
        checkOutput($sformatf("vec%0d sink_ready", j), sink_ready, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, vecs[j].e, vecs[j].re, vecs[j].im, 2'(j % 4));
      end else begin
        applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 16'h0, 2'b00);
      end
      step();
    end
    repeat (2) step();

`ifdef FFT_FRAME_CHECK_EN
    runFrame(501, 500, 500, 2'b10, "short frame");
    repeat (2) step();
`endif
    runFrame(N, N - 1, -1, 2'b00, "full frame");
    repeat (2) step();

    stallTest();
    repeat (3) step();

    // Reset in the middle of a frame with both stages occupied.
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b1, j == 0, 1'b0, (j == 0) ? 6'h3D : 6'd0, 16'h0100, 16'hFF00, 2'b01);
      step();
    end
    checkOutput("pre-reset pipeline full", source_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async reset source_valid", source_valid, 0);
    checkOutput("async reset source_real", source_real, 0);
    checkOutput("async reset source_imag", source_imag, 0);
    checkOutput("async reset source_sop/error", {source_sop, source_error}, 0);
    checkOutput("async reset sink_ready", {sink_ready, sink_ready17}, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 16'h0, 2'b00);
    repeat (2) step();
    reset_n = 1'b1;
    stale = 0;
    for (int j = 0; j < 4; j++) begin
      step();
      if (source_valid || source_valid17) stale++;
    end
    checkOutput("stale samples after reset", stale, 0);

    applyStimulus(1'b1, 1'b1, 1'b1, 6'h3D, 16'h0100, 16'hFF00, 2'b00);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 16'h0, 2'b00);
    step();
    checkOutput("post-reset frame valid", source_valid, 1);
    checkOutput("post-reset frame real", longint'($signed(source_real)), 2048);
    checkOutput("post-reset frame error", source_error, SOLO_ERR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_exp_normalizer.md
FFT_EXP_NORMALIZER -- requirements
Module: fft_exp_normalizer

Interface
REQ-001 Parameter N, default 1024, frame length in samples (power of two, 8..65536).
REQ-002 Parameter OUT_W, default 24, output sample width (17..32).
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 sink_valid / sink_ready  input / output  1 / 1  upstream handshake from FFT source port, ready latency 0.
REQ-006 sink_error  input  2  upstream error flags.
REQ-007 sink_sop / sink_eop  input  1 / 1  frame start / end markers.
REQ-008 sink_real / sink_imag  input  16 / 16  signed FFT bin.
REQ-009 sink_exp  input  6  signed block exponent; true value = sample * 2^(-exp).
REQ-010 source_valid / source_ready  output / input  1 / 1  downstream handshake, ready latency 0.
REQ-011 source_error  output  2  error flags.
REQ-012 source_sop / source_eop  output  1 / 1  frame markers, aligned with data.
REQ-013 source_real / source_imag  output  OUT_W / OUT_W  signed normalized bin.

Function
REQ-014 Transfer on either port occurs only in a cycle with valid and ready both high.
REQ-015 Two-stage pipeline (S1 capture, S2 shift/saturate); latency 2 cycles with source_ready held high.
REQ-016 Pipeline advances when S2 empty or source_ready high; sink_ready equals that advance condition, combinationally.
REQ-017 Full throughput: one sample per cycle with source_ready constantly high.
REQ-018 source_valid held and all source_* held stable while source_valid high and source_ready low.
REQ-019 Exponent latched from sink_exp on the sop-flagged transfer; latched value applies to every sample of that frame; sink_exp ignored on non-sop samples.
REQ-020 exp <= 0: sample sign-extended then shifted left by -exp; exp > 0: arithmetic right shift by exp (floor).
REQ-021 Result exceeding OUT_W signed range saturates to 2^(OUT_W-1)-1 or -2^(OUT_W-1), per component independently.
REQ-022 sop, eop and error pass through the pipeline aligned with their sample.
REQ-023 Simultaneous sop and eop on one sample: treated as one-sample frame (exp latched and used for that sample).

Reset
REQ-024 reset_n low asynchronously clears: S1/S2 valid, source_valid=0, source_sop=0, source_eop=0, source_error=0, source_real=0, source_imag=0, latched exp=0, frame counter=0, frame state=IDLE.
REQ-025 sink_ready=0 while reset_n low; first transfer accepted the cycle after reset_n deasserts.
REQ-026 Reset mid-frame discards all in-flight samples; the next frame must begin with sop.

Configuration
REQ-027 Macro FFT_FRAME_CHECK_EN enables frame-integrity checking.
REQ-028 With FFT_FRAME_CHECK_EN defined: FSM IDLE/IN_FRAME plus sample counter (log2 N bits); IDLE --sop--> IN_FRAME; IN_FRAME --eop--> IDLE; counter reset to 0 on sop, +1 per transfer.
REQ-029 With check: sample accepted in IDLE without sop -> source_error[0] set on it, exp 0 used, state stays IDLE.
REQ-030 With check: sop while IN_FRAME -> source_error[1] set on that sample, frame restarts (counter 0, exp relatched).
REQ-031 With check: eop at counter != N-1, or counter reaching N-1 without eop -> source_error[1] set on that sample, state to IDLE.
REQ-032 With check, source_error = checker flags OR sink_error; without macro, source_error = sink_error, no FSM/counter, exp still latched on sop.

Verification
REQ-033 Frame N=1024, exp=-3 at sop, real=0x0100 imag=0xFF00, ready high -> outputs 0x000800 / 0xFFF800, first output 2 cycles after input, sop/eop on samples 0/1023.
REQ-034 exp=+2, real=0x8001 (-32767) -> real=-8192 (floor), imag=0x0003 -> 0.
REQ-035 OUT_W=17, exp=-4, real=0x7FFF, imag=0x8000 -> real=65535, imag=-65536 (saturated).
REQ-036 source_ready toggled 1-0-0-1 pseudo-randomly across a full frame -> no sample lost/duplicated, outputs stable while stalled, sink_ready low whenever S2 full and ready low.
REQ-037 FFT_FRAME_CHECK_EN, eop at sample 500 of N=1024 -> source_error=2'b10 on sample 500, next sop frame clean (error 0).
REQ-038 reset_n pulsed low mid-frame with samples in S1/S2 -> all outputs 0 asynchronously, no stale sample emitted after release.
